// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the 20 MHz domain reset sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {
      ST_HOLD    = 2'd0,
      ST_STABLE  = 2'd1,
      ST_STRETCH = 2'd2,
      ST_RUN     = 2'd3
   } seq_state_t;

   localparam int unsigned LOCK_DROPS_W = 8;

   // One spare bit above the larger terminal count keeps the compare simple.
   function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Two-flop synchronizer with asynchronous active-low clear.
module sync_ff (
   input  logic clock,
   input  logic clr_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or negedge clr_n) begin
      if (!clr_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Stretched system reset for the core: waits for stable PLL lock, holds reset
// for a programmable time, and counts lock losses seen while running.
//
// state   | meaning
// HOLD    | no synchronized lock; reset asserted
// STABLE  | lock present, counting LOCK_CYCLES of qualification
// STRETCH | lock qualified, holding reset for STRETCH_CYCLES
// RUN     | reset released
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned LOCK_CYCLES    = 1024,
   parameter int unsigned STRETCH_CYCLES = 16
) (
   input  logic                    clock,
   input  logic                    reset_n,
   input  logic                    pll_locked,
   input  logic                    soft_reset_req,
   output logic                    cpu_reset,
   output logic                    running,
   output logic [1:0]              state,
   output logic [LOCK_DROPS_W-1:0] lock_drops
);

   localparam int unsigned CNT_W = cnt_width(LOCK_CYCLES, STRETCH_CYCLES);
   localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
   localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);

   logic       rst_int_n;
   logic       locked_s;
   seq_state_t state_q, state_d;
   logic [CNT_W-1:0] cnt, cnt_d;
   logic       cpu_reset_d, running_d;
   logic       drop_inc;

   sync_ff u_rst_sync (
      .clock (clock),
      .clr_n (reset_n),
      .d     (1'b1),
      .q     (rst_int_n)
   );

   sync_ff u_lock_sync (
      .clock (clock),
      .clr_n (rst_int_n),
      .d     (pll_locked),
      .q     (locked_s)
   );

   always_ff @(posedge clock or negedge rst_int_n) begin
      if (!rst_int_n) begin
         state_q   <= ST_HOLD;
         cnt       <= '0;
         cpu_reset <= 1'b1;
         running   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt       <= cnt_d;
         cpu_reset <= cpu_reset_d;
         running   <= running_d;
      end
   end

   // Lock loss is checked first in every state so it always wins over soft reset.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt;
      drop_inc = 1'b0;
      unique case (state_q)
         ST_HOLD: begin
            if (locked_s) begin
               state_d = ST_STABLE;
               cnt_d   = '0;
            end
         end
         ST_STABLE: begin
            if (!locked_s) begin
               state_d = ST_HOLD;
            end else if (cnt == LOCK_LAST) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         ST_STRETCH: begin
            if (!locked_s) begin
               state_d = ST_HOLD;
            end else if (soft_reset_req) begin
               cnt_d = '0;
            end else if (cnt == STRETCH_LAST) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (!locked_s) begin
               state_d  = ST_HOLD;
               drop_inc = 1'b1;
            end else if (soft_reset_req) begin
               state_d = ST_STRETCH;
               cnt_d   = '0;
            end
         end
         default: state_d = ST_HOLD;
      endcase
   end

   always_comb begin
      cpu_reset_d = (state_d != ST_RUN);
      running_d   = (state_d == ST_RUN);
   end

   always_ff @(posedge clock or negedge rst_int_n) begin
      if (!rst_int_n) begin
         lock_drops <= '0;
      end else if (drop_inc && (lock_drops != {LOCK_DROPS_W{1'b1}})) begin
         lock_drops <= lock_drops + 1'b1;
      end
   end

   assign state = state_q;

endmodule
